regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised successor to the CPU register file.
- Configurable data width, depth and number of read ports.
- Two write ports with per-byte enables on port 0.
- Optional write-to-read bypass and hardwired zero register.
- Background clear sequencer that wipes the array one entry per cycle without a full reset.
- Sits between the decode stage (read ports) and the writeback stage (write ports) of the MIPS pipeline.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- wr0_en  in  1  write port 0 enable
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr0_be  in  DATA_W/8  write port 0 byte enables
- wr1_en  in  1  write port 1 enable (full word)
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
- clr_req  in  1  one-cycle pulse starting a background clear
- clr_busy  out  1  high while a clear sweep is in progress
- wr_conflict  out  1  registered flag: both write ports hit the same address last cycle

Behaviour:
- Reset:
  - All entries become 0 at the clk edge where reset=1.
  - FSM goes to IDLE; clr_busy=0; wr_conflict=0.
  - Reset mid-sweep aborts the sweep.
- Writes:
  - Take effect at the rising edge.
  - wr0 updates only the bytes whose wr0_be bit is 1; wr0_be=0 with wr0_en=1 is a no-op.
  - wr1 writes the full word.
- Simultaneous writes to the same address:
  - Port 1 wins on every byte.
  - wr_conflict=1 on the following cycle, for one cycle per occurrence.
- ZERO_REG=1: writes to address 0 are discarded; reads of address 0 return 0 regardless of bypass.
- Reads are combinational from the array (0-cycle latency).
- BYPASS=1, when a read address matches an active write address in the same cycle, rd_data returns the post-write value:
  - merged bytes from wr0 under wr0_be, then wr1 overlay, on top of the stored word.
  - Reads see exactly what the array will hold after the edge.
- BYPASS=0: reads return the pre-edge stored value.
- Clear FSM has states IDLE and SWEEP; idx counter is ADDR_W bits.
  - IDLE: clr_req=1 -> SWEEP, idx=0, clr_busy=1 from the next cycle.
  - SWEEP: each cycle writes 0 to entry idx, then idx+1. After writing entry 2**ADDR_W-1, return to IDLE (sweep takes exactly 2**ADDR_W cycles).
  - clr_req while in SWEEP is ignored; there is no restart.
- Normal writes during a sweep:
  - Are accepted.
  - Same-cycle collision with the sweep index: the normal write wins.
  - Entries already swept keep later writes; entries not yet swept will be zeroed when idx reaches them.
  - Bypass does not forward sweep zeros.
- Unsupported parameters (DATA_W not a multiple of 8, NUM_RD outside 1..4) trigger an elaboration-time $error.

Test Plan:
- Reset then read sweep:
  - Stimulus: reset=1 for one edge; read addresses 0..31 on all ports.
  - Required: all rd_data=0; clr_busy=0; wr_conflict=0.
- Walking write/read:
  - Stimulus: for i=31..1, wr0_en=1, wr0_be=4'hF, wr0_addr=i, wr0_data=32'h55aaaa55^i; next cycle rd_addr port0=i.
  - Required: value matches. Writing address 0 with 32'hFFFFFFFF reads back 0.
- Byte enables:
  - Stimulus: entry 5 = 32'h11223344; wr0 to 5 with be=4'b0101, data=32'hAABBCCDD.
  - Required: entry 5 reads 32'h11BB33DD.
- Dual-port conflict and bypass:
  - Stimulus: same cycle, wr0(7, 32'h1, be F) and wr1(7, 32'h2), with rd_addr port1=7.
  - Required: rd_data port1=32'h2 in that cycle (BYPASS=1); entry 7=32'h2 afterward; wr_conflict=1 for exactly one cycle.
- Background clear with interleaved write:
  - Stimulus: fill all entries with nonzero values; pulse clr_req; 3 cycles later write 32'hCAFE to address 2 and 32'hBEEF to address 20.
  - Required: clr_busy high for 32 cycles; afterward entry 2=32'hCAFE, entry 20=0, all others 0.
- Reset mid-sweep:
  - Stimulus: assert reset at sweep cycle 10.
  - Required: clr_busy=0 next cycle; all entries 0; a subsequent clr_req starts a new full 32-cycle sweep.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multi-port register file: byte-enabled write port 0, full-word write port 1,
// NUM_RD combinational read ports with optional bypass, and a background clear sweep.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic [DATA_W/8-1:0]      wr0_be,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     wr_conflict
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = DATA_W / 8;
  localparam bit ZR     = (ZERO_REG != 0);
  localparam bit BP     = (BYPASS != 0);

  if ((DATA_W % 8) != 0 || NUM_RD < 1 || NUM_RD > 4) begin : g_bad_param
    $error("regfile_multiport: DATA_W must be a multiple of 8 and NUM_RD in 1..4");
  end

  typedef enum logic {IDLE, SWEEP} clr_state_e;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wr_conflict_q, wr_conflict_d;
  logic              sweep_we;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Writes to the hardwired zero entry are dropped before they reach the array.
  logic wr0_hit, wr1_hit;
  assign wr0_hit = wr0_en && !(ZR && wr0_addr == '0);
  assign wr1_hit = wr1_en && !(ZR && wr1_addr == '0);

  assign wr_conflict_d = wr0_en && wr1_en && (wr0_addr == wr1_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (clr_req) begin
        state_d = SWEEP;
        idx_d   = '0;
      end
      SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state_q == SWEEP);
    sweep_we = (state_q == SWEEP);
  end

  assign wr_conflict = wr_conflict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is deliberately reset entry-by-entry; this costs a reset fan-out
      // on every bit but the block contract is an all-zero file after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: later non-blocking assignments to the same bits win, which gives the
      // priority sweep < wr0 < wr1 without extra muxing.
      if (sweep_we) mem_q[idx_q] <= '0;
      if (wr0_hit) begin
        for (int b = 0; b < NBYTES; b++)
          if (wr0_be[b]) mem_q[wr0_addr][b*8 +: 8] <= wr0_data[b*8 +: 8];
      end
      if (wr1_hit) mem_q[wr1_addr] <= wr1_data;
    end
  end

  // Bypass mirrors the write merge above but never forwards sweep zeros.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      word = mem_q[addr];
      if (BP) begin
        if (wr0_en && wr0_addr == addr) begin
          for (int b = 0; b < NBYTES; b++)
            if (wr0_be[b]) word[b*8 +: 8] = wr0_data[b*8 +: 8];
        end
        if (wr1_en && wr1_addr == addr) word = wr1_data;
      end
      if (ZR && addr == '0) word = '0;
    end
    assign rd_data[k*DATA_W +: DATA_W] = word;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport (default parameters: 32x32, 2 read ports,
// zero register and bypass enabled).
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr0_en;
  logic [4:0]  wr0_addr;
  logic [31:0] wr0_data;
  logic [3:0]  wr0_be;
  logic        wr1_en;
  logic [4:0]  wr1_addr;
  logic [31:0] wr1_data;
  logic [4:0]  rd0, rd1;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        clr_req;
  logic        clr_busy;
  logic        wr_conflict;

  int checks = 0;
  int errors = 0;

  assign rd_addr = {rd1, rd0};

  regfile_multiport dut (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_be(wr0_be),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w0_en;
    logic [4:0]  w0_addr;
    logic [31:0] w0_data;
    logic [3:0]  w0_be;
    logic        w1_en;
    logic [4:0]  w1_addr;
    logic [31:0] w1_data;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        exp_conf;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0; wr0_be = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    clr_req = 1'b0;
  endtask

  task automatic write0(input logic [4:0] a, input logic [31:0] d);
    wr0_en = 1'b1; wr0_addr = a; wr0_data = d; wr0_be = 4'hF;
    step();
    idle_inputs();
  endtask

  task automatic fill_nonzero();
    for (int i = 1; i < 32; i++) write0(5'(i), 32'h1000 + i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    idle_inputs();
    rd0 = '0; rd1 = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Reset state and read sweep on both ports.
    check("rst_busy", 32'(clr_busy), 32'd0);
    check("rst_conflict", 32'(wr_conflict), 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd0 = 5'(i); rd1 = 5'(31 - i);
      #1;
      check("rst_rd0", rd_data[31:0], 32'h0);
      check("rst_rd1", rd_data[63:32], 32'h0);
    end

    // Walking write/read.
    for (int i = 31; i >= 1; i--) begin
      write0(5'(i), 32'h55aaaa55 ^ i);
      rd0 = 5'(i);
      #1;
      check("walk_rd", rd_data[31:0], 32'h55aaaa55 ^ i);
    end
    write0(5'd0, 32'hFFFFFFFF);
    rd0 = 5'd0;
    #1;
    check("zero_reg_rd", rd_data[31:0], 32'h0);

    // Table: byte enables, bypass, dual-port conflict, zero register.
    vecs[0]  = '{1'b1, 5'd5,  32'h11223344, 4'hF, 1'b0, 5'd0,  32'h0,      5'd5,  5'd0,  32'h11223344, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 5'd5,  32'hAABBCCDD, 4'h5, 1'b0, 5'd0,  32'h0,      5'd5,  5'd5,  32'h11BB33DD, 32'h11BB33DD, 1'b0};
    vecs[2]  = '{1'b1, 5'd5,  32'hFFFFFFFF, 4'h0, 1'b0, 5'd0,  32'h0,      5'd5,  5'd3,  32'h11BB33DD, 32'h55AAAA56, 1'b0};
    vecs[3]  = '{1'b1, 5'd7,  32'h1,        4'hF, 1'b1, 5'd7,  32'h2,      5'd5,  5'd7,  32'h11BB33DD, 32'h2,        1'b1};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,      5'd7,  5'd7,  32'h2,        32'h2,        1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd0,  32'hDEAD,   5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
    vecs[6]  = '{1'b1, 5'd3,  32'h0000BEEF, 4'h3, 1'b0, 5'd0,  32'h0,      5'd3,  5'd6,  32'h55AABEEF, 32'h55AAAA53, 1'b0};
    vecs[7]  = '{1'b1, 5'd9,  32'hAAAA0000, 4'hF, 1'b1, 5'd10, 32'h10101010, 5'd9, 5'd10, 32'hAAAA0000, 32'h10101010, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,      5'd9,  5'd3,  32'hAAAA0000, 32'h55AABEEF, 1'b0};
    vecs[9]  = '{1'b1, 5'd11, 32'hFFFFFFFF, 4'h1, 1'b1, 5'd11, 32'h0,      5'd11, 5'd10, 32'h0,        32'h10101010, 1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,      5'd11, 5'd0,  32'h0,        32'h0,        1'b0};

    for (int v = 0; v < 11; v++) begin
      wr0_en = vecs[v].w0_en; wr0_addr = vecs[v].w0_addr;
      wr0_data = vecs[v].w0_data; wr0_be = vecs[v].w0_be;
      wr1_en = vecs[v].w1_en; wr1_addr = vecs[v].w1_addr; wr1_data = vecs[v].w1_data;
      rd0 = vecs[v].r0; rd1 = vecs[v].r1;
      #1;
      check($sformatf("vec%0d_rd0", v), rd_data[31:0], vecs[v].exp0);
      check($sformatf("vec%0d_rd1", v), rd_data[63:32], vecs[v].exp1);
      step();
      check($sformatf("vec%0d_conflict", v), 32'(wr_conflict), 32'(vecs[v].exp_conf));
      idle_inputs();
    end
    rd0 = 5'd7;
    #1;
    check("entry7_after_conflict", rd_data[31:0], 32'h2);

    // Background clear with interleaved writes and an ignored second clr_req.
    fill_nonzero();
    clr_req = 1'b1;
    #1;
    check("clr_busy_before_edge", 32'(clr_busy), 32'd0);
    step();
    clr_req = 1'b0;
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 100) begin
      if (cnt == 3) begin
        wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'hCAFE; wr0_be = 4'hF;
        wr1_en = 1'b1; wr1_addr = 5'd20; wr1_data = 32'hBEEF;
        rd0 = 5'd2; rd1 = 5'd20;
        #1;
        check("sweep_bypass_wr0", rd_data[31:0], 32'hCAFE);
        check("sweep_bypass_wr1", rd_data[63:32], 32'hBEEF);
      end
      if (cnt == 5) begin
        rd0 = 5'd5; rd1 = 5'd4;
        #1;
        check("sweep_idx_not_forwarded", rd_data[31:0], 32'h1005);
        check("sweep_already_cleared", rd_data[63:32], 32'h0);
      end
      if (cnt == 10) clr_req = 1'b1;
      step();
      idle_inputs();
      cnt++;
    end
    check("sweep_busy_cycles", 32'(cnt), 32'd32);
    for (int i = 0; i < 32; i++) begin
      rd0 = 5'(i);
      #1;
      check($sformatf("after_clear_%0d", i), rd_data[31:0], (i == 2) ? 32'hCAFE : 32'h0);
    end

    // Reset in the middle of a sweep.
    fill_nonzero();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("busy_mid_sweep", 32'(clr_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("busy_after_reset", 32'(clr_busy), 32'd0);
    check("conflict_after_reset", 32'(wr_conflict), 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd1 = 5'(i);
      #1;
      check($sformatf("after_reset_%0d", i), rd_data[63:32], 32'h0);
    end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
    check("resweep_busy_cycles", 32'(cnt), 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
